// File: rtl/tao_exu_mc_if.sv
// Handshake bundle between decode/regfile-read, the execute stage and writeback.
// master: upstream driver side (issues instructions, accepts results).
// slave:  the execute stage.
interface tao_exu_mc_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned REG_ADDR = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [XLEN-1:0]     in_pc;
    logic [XLEN-1:0]     in_src1;
    logic [XLEN-1:0]     in_src2;
    logic [XLEN-1:0]     in_imm;
    logic [3:0]          in_alu_op;
    logic                in_op1_pc;
    logic                in_op2_imm;
    logic                in_jump;
    logic                in_jalr;
    logic                in_branch;
    logic [2:0]          in_br_cond;
    logic                in_mul;
    logic                in_ebreak;
    logic [REG_ADDR-1:0] in_rdidx;
    logic                in_rdwen;

    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_result;
    logic [REG_ADDR-1:0] out_rdidx;
    logic                out_rdwen;
    logic                out_ebreak;

    modport master (
        output in_valid, in_pc, in_src1, in_src2, in_imm, in_alu_op, in_op1_pc, in_op2_imm,
               in_jump, in_jalr, in_branch, in_br_cond, in_mul, in_ebreak, in_rdidx, in_rdwen,
               out_ready,
        input  in_ready, out_valid, out_result, out_rdidx, out_rdwen, out_ebreak
    );

    modport slave (
        input  in_valid, in_pc, in_src1, in_src2, in_imm, in_alu_op, in_op1_pc, in_op2_imm,
               in_jump, in_jalr, in_branch, in_br_cond, in_mul, in_ebreak, in_rdidx, in_rdwen,
               out_ready,
        output in_ready, out_valid, out_result, out_rdidx, out_rdwen, out_ebreak
    );
endinterface

// File: rtl/tao_exu_mc.sv
// Handshaked execute stage: ALU, branch/jump resolution and the architectural PC.
// Optional iterative shift-add multiplier enabled by defining TAO_EXU_MUL_EN.
module tao_exu_mc #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     REG_ADDR = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h80000000
) (
    input  logic            clk,
    input  logic            rst,
    tao_exu_mc_if.slave     bus,
    output logic [XLEN-1:0] pc
);
    localparam int unsigned SHW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e              state_q, state_d;
    logic [XLEN-1:0]     pc_q;
    logic [XLEN-1:0]     npc_q;
    logic [XLEN-1:0]     res_q;
    logic [REG_ADDR-1:0] rdidx_q;
    logic                rdwen_q;
    logic                ebreak_q;

    logic                in_ready;
    logic                out_valid;
    logic                accept;
    logic                commit;
    logic                mul_sel;
    logic                mul_last;
    logic [XLEN-1:0]     mul_add;

    logic [XLEN-1:0]     op1, op2, alu_res, wb_res, target, pc_plus4, npc;
    logic [SHW-1:0]      shamt;
    logic                taken;

    // ALU, branch comparator and next-PC selection on the presented instruction
    always_comb begin
        op1      = bus.in_op1_pc  ? bus.in_pc  : bus.in_src1;
        op2      = bus.in_op2_imm ? bus.in_imm : bus.in_src2;
        shamt    = op2[SHW-1:0];
        pc_plus4 = bus.in_pc + XLEN'(4);
        alu_res  = '0;
        case (bus.in_alu_op)
            4'd0:    alu_res = op1 + op2;
            4'd1:    alu_res = op1 - op2;
            4'd2:    alu_res = op1 << shamt;
            4'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
            4'd4:    alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
            4'd5:    alu_res = op1 ^ op2;
            4'd6:    alu_res = op1 >> shamt;
            4'd7:    alu_res = XLEN'($signed(op1) >>> shamt);
            4'd8:    alu_res = op1 | op2;
            4'd9:    alu_res = op1 & op2;
            default: alu_res = '0;
        endcase
        taken = 1'b0;
        case (bus.in_br_cond)
            3'b000:  taken = (bus.in_src1 == bus.in_src2);
            3'b001:  taken = (bus.in_src1 != bus.in_src2);
            3'b100:  taken = ($signed(bus.in_src1) <  $signed(bus.in_src2));
            3'b101:  taken = ($signed(bus.in_src1) >= $signed(bus.in_src2));
            3'b110:  taken = (bus.in_src1 <  bus.in_src2);
            3'b111:  taken = (bus.in_src1 >= bus.in_src2);
            default: taken = 1'b0;
        endcase
        target = bus.in_jalr ? ((bus.in_src1 + bus.in_imm) & ~XLEN'(1)) : (bus.in_pc + bus.in_imm);
        npc    = (bus.in_jump || (bus.in_branch && taken)) ? target : pc_plus4;
        wb_res = bus.in_jump ? pc_plus4 : alu_res;
    end

`ifdef TAO_EXU_MUL_EN
    localparam int unsigned         CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(XLEN - 1);

    logic [XLEN-1:0]  mcand_q, mplier_q;
    logic [CNT_W-1:0] cnt_q;

    assign mul_sel  = bus.in_mul;
    assign mul_last = (state_q == StMul) && (cnt_q == CNT_LAST);
    assign mul_add  = mplier_q[0] ? mcand_q : '0;

    // Multiplicand shifts left and multiplier shifts right, one bit retired per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (accept && mul_sel) begin
            mcand_q  <= op1;
            mplier_q <= op2;
            cnt_q    <= '0;
        end else if (state_q == StMul) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end
`else
    assign mul_sel  = 1'b0;
    assign mul_last = 1'b0;
    assign mul_add  = '0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake decode; a DONE commit may overlap a new accept
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        commit    = 1'b0;
        unique case (state_q)
            StIdle: in_ready = 1'b1;
            StMul:  if (mul_last) state_d = StDone;
            StDone: begin
                out_valid = 1'b1;
                in_ready  = bus.out_ready;
                commit    = bus.out_ready;
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        accept = bus.in_valid && in_ready;
        if (accept) state_d = mul_sel ? StMul : StDone;
    end

    // Result/control capture at accept, multiply accumulation, PC update at commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            npc_q    <= '0;
            res_q    <= '0;
            rdidx_q  <= '0;
            rdwen_q  <= 1'b0;
            ebreak_q <= 1'b0;
        end else begin
            if (commit) pc_q <= npc_q;
            if (accept) begin
                res_q    <= mul_sel ? '0 : wb_res;
                npc_q    <= npc;
                rdidx_q  <= bus.in_rdidx;
                rdwen_q  <= bus.in_rdwen && !bus.in_branch && !bus.in_ebreak;
                ebreak_q <= bus.in_ebreak;
            end else if (state_q == StMul) begin
                res_q <= res_q + mul_add;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_result = res_q;
    assign bus.out_rdidx  = rdidx_q;
    assign bus.out_rdwen  = rdwen_q;
    assign bus.out_ebreak = ebreak_q;
    assign pc             = pc_q;
endmodule

// File: tb/tb_tao_exu_mc.sv
// Directed self-checking bench for tao_exu_mc (works with or without TAO_EXU_MUL_EN).
module tb_tao_exu_mc;
    logic        clk;
    logic        rst;
    logic [31:0] pc;
    int          n_cmp;
    int          n_err;
    int          lat;

    typedef struct {
        logic [3:0]  op;
        logic        sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [2:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic        tk;
    } br_t;

    vec_t vecs[12];
    br_t  brs[8];

    tao_exu_mc_if #(.XLEN(32), .REG_ADDR(4)) bus ();

    tao_exu_mc #(
        .XLEN    (32),
        .REG_ADDR(4),
        .RESET_PC(32'h80000000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .pc (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        bus.in_valid   = 1'b0;
        bus.in_pc      = '0;
        bus.in_src1    = '0;
        bus.in_src2    = '0;
        bus.in_imm     = '0;
        bus.in_alu_op  = '0;
        bus.in_op1_pc  = 1'b0;
        bus.in_op2_imm = 1'b0;
        bus.in_jump    = 1'b0;
        bus.in_jalr    = 1'b0;
        bus.in_branch  = 1'b0;
        bus.in_br_cond = '0;
        bus.in_mul     = 1'b0;
        bus.in_ebreak  = 1'b0;
        bus.in_rdidx   = '0;
        bus.in_rdwen   = 1'b0;
    endtask

    task automatic apply_vec(input int i);
        clear_in();
        bus.in_valid   = 1'b1;
        bus.in_pc      = 32'h80000100 + 32'(4 * i);
        bus.in_alu_op  = vecs[i].op;
        bus.in_op1_pc  = vecs[i].sel;
        bus.in_op2_imm = vecs[i].sel;
        bus.in_src1    = vecs[i].a;
        bus.in_src2    = vecs[i].b;
        bus.in_imm     = vecs[i].b;
        bus.in_rdidx   = 4'(i);
        bus.in_rdwen   = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        vecs[0]  = '{4'd0,  1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000};
        vecs[1]  = '{4'd1,  1'b0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF};
        vecs[2]  = '{4'd2,  1'b0, 32'h00000001, 32'h00000023, 32'h00000008};
        vecs[3]  = '{4'd3,  1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
        vecs[4]  = '{4'd4,  1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vecs[5]  = '{4'd5,  1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
        vecs[6]  = '{4'd6,  1'b0, 32'h80000000, 32'h00000004, 32'h08000000};
        vecs[7]  = '{4'd7,  1'b0, 32'h80000000, 32'h00000004, 32'hF8000000};
        vecs[8]  = '{4'd8,  1'b0, 32'h000000F0, 32'h0000000F, 32'h000000FF};
        vecs[9]  = '{4'd9,  1'b0, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000};
        vecs[10] = '{4'd12, 1'b0, 32'h12345678, 32'h00000001, 32'h00000000};
        vecs[11] = '{4'd0,  1'b1, 32'hDEADBEEF, 32'h00000010, 32'h8000013C};

        brs[0] = '{3'b100, 32'hFFFFFFFF, 32'h1, 1'b1};
        brs[1] = '{3'b110, 32'hFFFFFFFF, 32'h1, 1'b0};
        brs[2] = '{3'b000, 32'h5,        32'h5, 1'b1};
        brs[3] = '{3'b001, 32'h5,        32'h5, 1'b0};
        brs[4] = '{3'b101, 32'hFFFFFFFF, 32'h1, 1'b0};
        brs[5] = '{3'b111, 32'hFFFFFFFF, 32'h1, 1'b1};
        brs[6] = '{3'b010, 32'h5,        32'h5, 1'b0};
        brs[7] = '{3'b011, 32'h5,        32'h6, 1'b0};

        rst = 1'b1;
        clear_in();
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset_pc", pc, 32'h80000000);
        check_eq("reset_out_valid", 32'(bus.out_valid), 32'h0);
        check_eq("reset_in_ready", 32'(bus.in_ready), 32'h1);
        check_eq("reset_out_result", bus.out_result, 32'h0);

        // ADD with immediate: 5 + (-1)
        bus.in_valid   = 1'b1;
        bus.in_pc      = 32'h80000000;
        bus.in_op2_imm = 1'b1;
        bus.in_src1    = 32'd5;
        bus.in_imm     = 32'hFFFFFFFF;
        bus.in_rdidx   = 4'd3;
        bus.in_rdwen   = 1'b1;
        @(negedge clk);
        clear_in();
        check_eq("add_valid", 32'(bus.out_valid), 32'h1);
        check_eq("add_result", bus.out_result, 32'h4);
        check_eq("add_rdidx", 32'(bus.out_rdidx), 32'h3);
        check_eq("add_rdwen", 32'(bus.out_rdwen), 32'h1);
        check_eq("add_pc_hold", pc, 32'h80000000);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_eq("add_pc_commit", pc, 32'h80000004);
        check_eq("add_idle", 32'(bus.out_valid), 32'h0);

        // JALR
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h80000010;
        bus.in_src1  = 32'h80000101;
        bus.in_imm   = 32'd4;
        bus.in_jump  = 1'b1;
        bus.in_jalr  = 1'b1;
        bus.in_rdidx = 4'd1;
        bus.in_rdwen = 1'b1;
        @(negedge clk);
        clear_in();
        check_eq("jalr_result", bus.out_result, 32'h80000014);
        @(negedge clk);
        check_eq("jalr_pc", pc, 32'h80000104);

        // Branch conditions
        for (int i = 0; i < 8; i++) begin
            clear_in();
            bus.in_valid   = 1'b1;
            bus.in_branch  = 1'b1;
            bus.in_br_cond = brs[i].c;
            bus.in_src1    = brs[i].a;
            bus.in_src2    = brs[i].b;
            bus.in_imm     = 32'd8;
            bus.in_pc      = 32'h80000020;
            bus.in_rdwen   = 1'b1;
            @(negedge clk);
            clear_in();
            check_eq($sformatf("br%0d_rdwen", i), 32'(bus.out_rdwen), 32'h0);
            @(negedge clk);
            check_eq($sformatf("br%0d_pc", i), pc, brs[i].tk ? 32'h80000028 : 32'h80000024);
        end

        // Ebreak
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'h80000400;
        bus.in_src1   = 32'd1;
        bus.in_src2   = 32'd1;
        bus.in_ebreak = 1'b1;
        bus.in_rdwen  = 1'b1;
        @(negedge clk);
        clear_in();
        check_eq("ebreak_flag", 32'(bus.out_ebreak), 32'h1);
        check_eq("ebreak_rdwen", 32'(bus.out_rdwen), 32'h0);
        @(negedge clk);
        check_eq("ebreak_pc", pc, 32'h80000404);

        // Backpressure: SUB held, a second instruction waits on in_ready
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'h80000030;
        bus.in_alu_op = 4'd1;
        bus.in_src1   = 32'd10;
        bus.in_src2   = 32'd3;
        bus.in_rdidx  = 4'd4;
        bus.in_rdwen  = 1'b1;
        @(negedge clk);
        bus.in_pc     = 32'h80000034;
        bus.in_alu_op = 4'd9;
        bus.in_src1   = 32'hC;
        bus.in_src2   = 32'hA;
        bus.in_rdidx  = 4'd5;
        for (int k = 0; k < 3; k++) begin
            check_eq("bp_result", bus.out_result, 32'h7);
            check_eq("bp_in_ready", 32'(bus.in_ready), 32'h0);
            check_eq("bp_pc", pc, 32'h80000404);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        clear_in();
        check_eq("bp_overlap_pc", pc, 32'h80000034);
        check_eq("bp_overlap_valid", 32'(bus.out_valid), 32'h1);
        check_eq("bp_overlap_result", bus.out_result, 32'h8);
        check_eq("bp_overlap_rdidx", 32'(bus.out_rdidx), 32'h5);
        @(negedge clk);
        check_eq("bp_final_pc", pc, 32'h80000038);
        check_eq("bp_final_idle", 32'(bus.out_valid), 32'h0);

        // Back-to-back ALU vectors
        apply_vec(0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_eq($sformatf("alu%0d_result", i), bus.out_result, vecs[i].exp);
            check_eq($sformatf("alu%0d_rdidx", i), 32'(bus.out_rdidx), 32'(i));
            check_eq($sformatf("alu%0d_in_ready", i), 32'(bus.in_ready), 32'h1);
            if (i < 11) apply_vec(i + 1);
            else clear_in();
        end
        @(negedge clk);
        check_eq("alu_final_pc", pc, 32'h80000130);

        // Multiply (or plain ADD when the multiplier is compiled out)
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mul    = 1'b1;
        bus.in_pc     = 32'h80000300;
        bus.in_src1   = 32'd7;
        bus.in_src2   = 32'hFFFFFFFF;
        bus.in_rdidx  = 4'd2;
        bus.in_rdwen  = 1'b1;
        @(posedge clk);
        #1 clear_in();
        lat = 0;
        @(negedge clk);
        lat++;
        check_eq("mul_in_ready", 32'(bus.in_ready), 32'h0);
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
`ifdef TAO_EXU_MUL_EN
        check_eq("mul_latency", 32'(lat), 32'd33);
        check_eq("mul_result", bus.out_result, 32'hFFFFFFF9);
`else
        check_eq("mul_latency", 32'(lat), 32'd1);
        check_eq("mul_result", bus.out_result, 32'h6);
`endif
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_eq("mul_pc", pc, 32'h80000304);

        // Asynchronous reset while an operation is outstanding
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mul    = 1'b1;
        bus.in_src1   = 32'd3;
        bus.in_src2   = 32'd3;
        bus.in_pc     = 32'h80000500;
        bus.in_rdwen  = 1'b1;
        @(posedge clk);
        #1 clear_in();
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_pc", pc, 32'h80000000);
        check_eq("arst_out_valid", 32'(bus.out_valid), 32'h0);
        check_eq("arst_in_ready", 32'(bus.in_ready), 32'h1);
        check_eq("arst_result", bus.out_result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("arst_no_commit_valid", 32'(bus.out_valid), 32'h0);
        check_eq("arst_no_commit_pc", pc, 32'h80000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tao_exu_mc.md
Name: tao_exu_mc

Overview:
- Parametrised, handshaked successor to the single-cycle execute stage.
- Accepts one decoded instruction with operand values already read, and computes the ALU result, branch/jump target and next PC.
- Holds the architectural PC register, which advances only when a result commits.
- Sits between decode/regfile-read and writeback; the optional iterative multiplier makes latency variable.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR, 4, destination register index width.
- RESET_PC, 32'h80000000, PC value after reset (XLEN bits).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- in_valid  in  1  instruction presented.
- in_ready  out  1  unit can accept.
- in_pc  in  XLEN  PC of instruction.
- in_src1  in  XLEN  rs1 value.
- in_src2  in  XLEN  rs2 value.
- in_imm  in  XLEN  sign-extended immediate.
- in_alu_op  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; 10-15 yield 0.
- in_op1_pc  in  1  op1 = in_pc, else in_src1.
- in_op2_imm  in  1  op2 = in_imm, else in_src2.
- in_jump  in  1  JAL/JALR; result = in_pc+4.
- in_jalr  in  1  target = (in_src1+in_imm)&~1, else in_pc+in_imm.
- in_branch  in  1  conditional branch.
- in_br_cond  in  3  RISC-V funct3 of branch.
- in_mul  in  1  MUL (low XLEN bits), only with the optional feature.
- in_ebreak  in  1  ebreak marker.
- in_rdidx  in  REG_ADDR  destination index.
- in_rdwen  in  1  destination write enable.
- out_valid  out  1  result held.
- out_ready  in  1  writeback accepts.
- out_result  out  XLEN  writeback data.
- out_rdidx  out  REG_ADDR  destination index.
- out_rdwen  out  1  write enable.
- out_ebreak  out  1  ebreak committed with this result.
- pc  out  XLEN  architectural PC.

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values:
  - state = IDLE, pc = RESET_PC, all out_* = 0, mul counter = 0.
  - A reset asserted mid-multiply abandons the operation; no commit occurs.
- States: IDLE, MUL, DONE.
- in_ready:
  - 1 in IDLE.
  - 1 in DONE when out_ready=1, giving back-to-back throughput of one per cycle.
  - 0 in MUL.
- Accept (in_valid & in_ready) with in_mul=0:
  - Result, target and controls are registered; next state is DONE.
  - Latency is 1 cycle.
- Accept with in_mul=1: next state is MUL; see Optional Feature.
- ALU semantics:
  - Shift amount is op2[log2(XLEN)-1:0].
  - SLT/SLTU produce 1 or 0, zero-extended.
  - Add/sub wrap modulo 2^XLEN.
- Branch conditions: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU, compared on in_src1/in_src2. Encodings 010 and 011 are not taken.
- Next PC:
  - Target when in_jump, or in_branch and taken.
  - Otherwise in_pc+4.
  - The next PC is captured at accept.
- Branch commit: out_rdwen = 0 regardless of in_rdwen.
- Ebreak commit: out_rdwen = 0 and out_ebreak = 1.
- DONE state:
  - out_valid = 1; outputs are stable until out_ready.
  - On out_valid & out_ready, pc <= captured next PC.
  - If a new accept occurs in the same cycle, reload DONE (or enter MUL); otherwise go to IDLE.
- PC holds in every cycle without a commit.
- in_* inputs are sampled only at accept; later changes are ignored.

Optional Feature:
- Macro: TAO_EXU_MUL_EN.
- Defined:
  - in_mul=1 selects an iterative shift-add multiplier in state MUL, retiring one multiplier bit per cycle for XLEN cycles, then entering DONE.
  - Accept-to-out_valid latency is XLEN+1 cycles.
  - Result is (src1*src2) mod 2^XLEN, with operands taken after the op1/op2 mux.
  - in_ready = 0 throughout MUL.
- Undefined:
  - in_mul is ignored and the MUL state is never entered.
  - The instruction executes as its in_alu_op in 1 cycle.

Test Plan:
- Reset then idle:
  - pc = 32'h80000000, out_valid = 0, in_ready = 1.
  - Assert rst during MUL -> same values immediately, with no clock edge required.
- ADD, op2_imm, src1 = 5, imm = 32'hFFFFFFFF, rdidx = 3:
  - Next cycle out_result = 4, out_rdidx = 3, out_rdwen = 1.
  - After out_ready, pc = 32'h80000004.
- JALR at in_pc = 32'h80000010, src1 = 32'h80000101, imm = 4:
  - out_result = 32'h80000014.
  - After commit, pc = 32'h80000104.
- BLT with src1 = 32'hFFFFFFFF, src2 = 1, imm = 8, pc = 32'h80000020:
  - Taken, pc -> 32'h80000028, out_rdwen = 0.
  - Same operands with BLTU -> not taken, pc -> 32'h80000024.
- Backpressure: hold out_ready = 0 for 3 cycles.
  - Outputs stable, in_ready = 0, pc unchanged.
  - Then out_ready = 1 with a new in_valid -> commit and accept in one cycle.
- With TAO_EXU_MUL_EN, MUL 7 * 32'hFFFFFFFF:
  - out_valid appears exactly 33 cycles after accept, out_result = 32'hFFFFFFF9.
  - Without the macro -> 1-cycle latency, ALU result.
